// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the register scoreboard: register count, zero register
// and register-address width.
package reg_scoreboard_pkg;
    localparam int          NREG     = 32;
    localparam int          RA_W     = 5;
    localparam logic [4:0]  REG_ZERO = 5'd0;
endpackage

// File: rtl/reg_scoreboard_pend_cnt.sv
// One saturating pending-write counter; inc and dec in the same cycle cancel,
// clear wins over both, and a decrement at zero raises a one-cycle underflow.
module reg_pend_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec_req,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt,
    output logic             underflow
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic dec;

    assign dec       = dec_req & (cnt != '0);
    assign underflow = dec_req & (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && !dec && cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc) begin
            cnt <= cnt - CNT_W'(1);
        end
    end
endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard between decode and writeback: counts in-flight writes per
// register and stalls decode until every source operand has been written back.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NREG  = reg_scoreboard_pkg::NREG,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [4:0]      id_rs,
    input  logic            id_rs_used,
    input  logic [4:0]      id_rt,
    input  logic            id_rt_used,
    input  logic            id_wen,
    input  logic [4:0]      id_rd,
    output logic            id_stall,
    output logic            id_issue,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            flush,
    output logic [NREG-1:0] busy,
    output logic            err_underflow
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [NREG-1:0]            uf;

    assign cnt[0]  = '0;
    assign uf[0]   = 1'b0;
    assign busy[0] = 1'b0;

    genvar i;
    generate
        for (i = 1; i < NREG; i++) begin : g_cnt
            logic inc_i, dec_i;
            assign inc_i = id_issue & id_wen & (id_rd == RA_W'(i));
            assign dec_i = wb_valid & ~flush & (wb_rd == RA_W'(i));

            reg_pend_cnt #(.CNT_W(CNT_W)) u_cnt (
                .clk       (clk),
                .reset     (reset),
                .inc       (inc_i),
                .dec_req   (dec_i),
                .clear     (flush),
                .cnt       (cnt[i]),
                .underflow (uf[i])
            );

            assign busy[i] = |cnt[i];
        end
    endgenerate

    // Only registered counts are consulted: a same-cycle writeback is not
    // visible through the combinational file read until after the edge.
    logic rs_pend, rt_pend, rd_sat;
    assign rs_pend = id_rs_used & (cnt[id_rs] != '0);
    assign rt_pend = id_rt_used & (cnt[id_rt] != '0);
    assign rd_sat  = id_wen & (id_rd != REG_ZERO) & (cnt[id_rd] == CNT_MAX);

    assign id_stall = id_valid & (rs_pend | rt_pend | rd_sat);
    assign id_issue = id_valid & ~id_stall & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_underflow <= 1'b0;
        end else if (|uf) begin
            err_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard; inputs change just after the
// falling edge, outputs are sampled 1 time unit later.
module tb_reg_scoreboard;
    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_rs_used, id_rt_used, id_wen;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_stall, id_issue;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] busy;
    logic        err_underflow;

    int n_cmp = 0;
    int n_err = 0;

    reg_scoreboard #(.NREG(32), .CNT_W(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rs_used    (id_rs_used),
        .id_rt         (id_rt),
        .id_rt_used    (id_rt_used),
        .id_wen        (id_wen),
        .id_rd         (id_rd),
        .id_stall      (id_stall),
        .id_issue      (id_issue),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .flush         (flush),
        .busy          (busy),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and apply one cycle of stimulus.
    task automatic step(input logic v, input logic [4:0] rs, input logic rsu,
                        input logic [4:0] rt, input logic rtu,
                        input logic w, input logic [4:0] rd,
                        input logic wbv, input logic [4:0] wbr, input logic fl);
        @(negedge clk);
        id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
        id_wen = w; id_rd = rd; wb_valid = wbv; wb_rd = wbr; flush = fl;
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [4:0] rd);
        step(1, 0, 0, 0, 0, 1, rd, 0, 0, 0);
    endtask

    task automatic rd_op(input logic [4:0] rs);
        step(1, rs, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wb(input logic [4:0] r);
        step(0, 0, 0, 0, 0, 0, 0, 1, r, 0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        idle();
        reset = 1'b0;
        idle();
        check("reset_busy", busy, 32'h0);
        check("reset_err", {31'b0, err_underflow}, 32'h0);
        check("reset_stall", {31'b0, id_stall}, 32'h0);

        // basic issue with both sources clean
        step(1, 3, 1, 4, 1, 1, 5, 0, 0, 0);
        check("basic_stall", {31'b0, id_stall}, 32'h0);
        check("basic_issue", {31'b0, id_issue}, 32'h1);
        idle();
        check("basic_busy", busy, 32'h0000_0020);
        wb(5);
        idle();
        check("basic_drain", busy, 32'h0);

        // RAW on r5 with release one cycle after writeback
        wr(5);
        check("raw_issue_t", {31'b0, id_issue}, 32'h1);
        rd_op(5);
        check("raw_stall_t1", {31'b0, id_stall}, 32'h1);
        check("raw_busy_t1", busy, 32'h0000_0020);
        rd_op(5);
        check("raw_stall_t2", {31'b0, id_stall}, 32'h1);
        step(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
        check("raw_stall_wb_cycle", {31'b0, id_stall}, 32'h1);
        check("raw_issue_wb_cycle", {31'b0, id_issue}, 32'h0);
        rd_op(5);
        check("raw_stall_t4", {31'b0, id_stall}, 32'h0);
        check("raw_issue_t4", {31'b0, id_issue}, 32'h1);
        check("raw_busy_t4", busy, 32'h0);

        // WAW saturation on r7 (max 3)
        for (int k = 0; k < 3; k++) begin
            wr(7);
            check("waw_issue", {31'b0, id_issue}, 32'h1);
        end
        wr(7);
        check("sat_stall", {31'b0, id_stall}, 32'h1);
        check("sat_busy", busy, 32'h0000_0080);
        wr(7);
        check("sat_stall_hold", {31'b0, id_stall}, 32'h1);
        step(1, 0, 0, 0, 0, 1, 7, 1, 7, 0);
        check("sat_stall_wb_cycle", {31'b0, id_stall}, 32'h1);
        wr(7);
        check("sat_release_stall", {31'b0, id_stall}, 32'h0);
        check("sat_release_issue", {31'b0, id_issue}, 32'h1);
        wb(7);
        wb(7);
        wb(7);
        idle();
        check("sat_drain_busy", busy, 32'h0);
        check("sat_drain_err", {31'b0, err_underflow}, 32'h0);

        // simultaneous issue and writeback on r9 cancel out
        wr(9);
        step(1, 0, 0, 0, 0, 1, 9, 1, 9, 0);
        check("incdec_issue", {31'b0, id_issue}, 32'h1);
        idle();
        check("incdec_busy", busy, 32'h0000_0200);
        wb(9);
        idle();
        check("incdec_drain", busy, 32'h0);

        // r0 never counts or stalls
        for (int k = 0; k < 10; k++) begin
            step(1, 0, 1, 0, 1, 1, 0, 0, 0, 0);
            check("r0_stall", {31'b0, id_stall}, 32'h0);
            check("r0_busy", busy, 32'h0);
        end

        // flush clears counters, blocks issue, discards same-cycle wb
        wr(2);
        wr(3);
        idle();
        check("pre_flush_busy", busy, 32'h0000_000C);
        step(1, 0, 0, 0, 0, 1, 6, 1, 4, 1);
        check("flush_issue", {31'b0, id_issue}, 32'h0);
        idle();
        check("post_flush_busy", busy, 32'h0);
        check("post_flush_err", {31'b0, err_underflow}, 32'h0);
        wb(2);
        idle();
        check("underflow_set", {31'b0, err_underflow}, 32'h1);
        check("underflow_busy", busy, 32'h0);
        idle();
        idle();
        check("underflow_sticky", {31'b0, err_underflow}, 32'h1);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        idle();
        check("underflow_reset", {31'b0, err_underflow}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Tracks in-flight writes to the 32 general-purpose registers of the 32x32 register file (two combinational read ports, one write port). The decode stage queries it before reading operands. It sits between decode (ID) and writeback (WB). It stalls ID until every source operand's pending writes have retired and been written into the file, so the register file's combinational read never returns stale data.

## Interface
Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero
- CNT_W, 2, width of the per-register pending-write counter; saturates at 2^CNT_W-1

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_rs  in  5  source register 1
- id_rs_used  in  1  instruction reads id_rs
- id_rt  in  5  source register 2
- id_rt_used  in  1  instruction reads id_rt
- id_wen  in  1  instruction will write id_rd
- id_rd  in  5  destination register
- id_stall  out  1  hold ID this cycle (combinational)
- id_issue  out  1  instruction leaves ID this cycle; equals id_valid & ~id_stall
- wb_valid  in  1  register-file write this cycle (same strobe as the file's wen)
- wb_rd  in  5  register-file write address
- flush  in  1  kill all speculative writers; clears every counter
- busy  out  NREG  bit i = counter i nonzero (registered)
- err_underflow  out  1  sticky; WB retired a register whose counter was 0

## Operation
- State: one CNT_W-bit counter cnt[i] per register; cnt[0] is constant 0.
- Stall condition, evaluated on the registered counters only:
  - id_valid & id_rs_used & cnt[id_rs]!=0, or
  - id_valid & id_rt_used & cnt[id_rt]!=0, or
  - id_valid & id_wen & id_rd!=0 & cnt[id_rd]==max (saturation).
- Writes to register 0 neither stall nor count.
- Same-cycle WB release is not forwarded: the file writes at the clock edge, so the operand is stale during that cycle. ID stalls in that cycle and releases in the next.
- Counter update per register i!=0, each cycle:
  - inc = id_issue & id_wen & id_rd==i
  - dec = wb_valid & wb_rd==i & cnt[i]!=0
  - cnt[i] <= cnt[i] + inc - dec; inc and dec together leave it unchanged.
- WAW is allowed: multiple pending writes to the same register are counted, up to max.
- If wb_valid & wb_rd!=0 & cnt[wb_rd]==0: cnt stays 0 and err_underflow sets.
  - err_underflow clears only on reset.
- flush has priority over inc and dec: all counters go to 0 next cycle.
  - id_issue is forced to 0 while flush is high.
  - A wb_valid in the flush cycle is discarded without raising err.
  - The pipeline guarantees no surviving writer is in flight when flush asserts.
- reset has priority over flush and everything else.

## Timing
- Reset values:
  - all cnt = 0
  - busy = 0
  - err_underflow = 0
  - id_stall = 0 unless the combinational condition holds (with cnt=0 only saturation can trigger, which it cannot).
- id_stall and id_issue are combinational from the current counters and the ID inputs, with no added latency. busy reflects the counters after the edge.
- Issue-to-visible latency is 1 cycle: an instruction issuing at cycle t with rd=r makes busy[r]=1 and stalls a reader of r from cycle t+1.
- WB-to-release latency is 1 cycle: wb_valid at cycle t clears the stall at cycle t+1, provided no other writes to that register are pending.
- A stalled instruction keeps its ID inputs stable; the block holds no handshake state of its own.

## Structure
- A shared package holds:
  - NREG
  - REG_ZERO = 5'd0
  - the register-address width constant, 5
- One sub-module is natural: reg_pend_cnt.
  - One saturating up/down counter with inc, dec, clear and an underflow pulse.
  - Instantiated NREG-1 times with generate.
  - The top keeps the decoders, the stall OR-tree and the sticky error flag.

## Test plan
- Reset, then id_valid, rs=3 used, rt=4 used, wen rd=5 -> id_stall=0, id_issue=1; next cycle busy=32'h0000_0020.
- Issue writer of r5 at t; reader of r5 at t+1..t+3; wb_valid wb_rd=5 at t+3 -> id_stall=1 for t+1..t+3, 0 at t+4, busy[5]=0 at t+4.
- Three issues writing r7 with CNT_W=2 -> cnt=3. A fourth writer to r7 -> id_stall=1 until one WB of r7, then issues next cycle.
- Issue writer of r9 while wb_valid wb_rd=9 in the same cycle, with cnt[9]=1 beforehand -> cnt[9] stays 1, busy[9]=1.
- rd=0 writer issued ten times; reader of r0 -> never stalls, busy[0]=0 throughout.
- Pending writes on r2, r3, then flush -> busy=0 next cycle. A later wb_valid wb_rd=2 -> err_underflow=1, stays 1 until reset.
